// File: rtl/risc23_pkg.sv
// Shared types and constants for the IITB-RISC-23 front end.
package risc23_pkg;

    typedef logic [15:0] pc_t;
    typedef logic [15:0] instr_t;

    localparam instr_t NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry instruction + PC holding buffer used while IF/ID is stalled.
module if_skid_buf
    import risc23_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic               clr,
    input  logic [INSTR_W-1:0] wr_instr,
    input  logic [PC_W-1:0]    wr_pc,
    output logic               full,
    output logic [INSTR_W-1:0] rd_instr,
    output logic [PC_W-1:0]    rd_pc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            full     <= 1'b0;
            rd_instr <= INSTR_W'(NOP_INSTR);
            rd_pc    <= '0;
        end else if (wr_en) begin
            full     <= 1'b1;
            rd_instr <= wr_instr;
            rd_pc    <= wr_pc;
        end else if (rd_en) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IITB-RISC-23 instruction fetch stage: PC, imem requests, IF/ID register.
// Optional performance counters enabled with `define IF_PERF_CNT_EN.
//
// state | meaning
// FETCH | free to launch a request at pc
// WAIT  | request at req_addr_q outstanding, result will be used
// DROP  | request outstanding but redirected away, result discarded
module if_fetch_unit
    import risc23_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int              PC_INC   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_pc,
    input  logic               stall_if_id,
    input  logic               flush_if_id,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_next
);

    fetch_state_e state_q, state_d;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    req_addr_q;
    logic               fetch_ok;
    logic               skid_full;
    logic               skid_wr;
    logic               skid_rd;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        fetch_ok  = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = !stall_pc && !skid_full && !redirect_valid;
                if (imem_req) begin
                    if (imem_ready) fetch_ok = 1'b1;
                    else            state_d  = WAIT;
                end
            end
            WAIT: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
                if (imem_ready) begin
                    state_d  = FETCH;
                    fetch_ok = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
                if (imem_ready) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Nothing is launched or accepted while reset is held.
        if (rst) begin
            imem_req = 1'b0;
            fetch_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && imem_req)
                req_addr_q <= pc_q;
            if (redirect_valid)
                pc_q <= redirect_pc;
            else if (fetch_ok)
                pc_q <= pc_q + PC_W'(PC_INC);
        end
    end

    // A fetch accepted under a stall parks in the skid; under a flush it is killed.
    assign skid_wr = fetch_ok && stall_if_id && !flush_if_id;
    assign skid_rd = !redirect_valid && !flush_if_id && !stall_if_id && skid_full;

    if_skid_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (skid_wr),
        .rd_en    (skid_rd),
        .clr      (redirect_valid),
        .wr_instr (imem_rdata),
        .wr_pc    (imem_addr),
        .full     (skid_full),
        .rd_instr (skid_instr),
        .rd_pc    (skid_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid   <= 1'b0;
            ifid_instr   <= INSTR_W'(NOP_INSTR);
            ifid_pc      <= '0;
            ifid_pc_next <= '0;
        end else if (redirect_valid || flush_if_id) begin
            ifid_valid <= 1'b0;
            ifid_instr <= INSTR_W'(NOP_INSTR);
        end else if (stall_if_id) begin
            ifid_valid <= ifid_valid;
        end else if (skid_full) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= skid_instr;
            ifid_pc      <= skid_pc;
            ifid_pc_next <= skid_pc + PC_W'(PC_INC);
        end else if (fetch_ok) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= imem_rdata;
            ifid_pc      <= imem_addr;
            ifid_pc_next <= imem_addr + PC_W'(PC_INC);
        end else begin
            ifid_valid <= 1'b0;
            ifid_instr <= INSTR_W'(NOP_INSTR);
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_ok && perf_fetch_cnt != 32'hFFFF_FFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((stall_pc || stall_if_id) && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; imem returns addr + 16'h1234 for every address.
module tb_if_fetch_unit;
    import risc23_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_pc, stall_if_id, flush_if_id;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        ifid_valid;
    logic [15:0] ifid_instr, ifid_pc, ifid_pc_next;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_pc       (stall_pc),
        .stall_if_id    (stall_if_id),
        .flush_if_id    (flush_if_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_next   (ifid_pc_next)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 16'h1234;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall_pc = 0; stall_if_id = 0; flush_if_id = 0;
        redirect_valid = 0; redirect_pc = '0; imem_ready = 1'b1;
        tick; tick;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++;
        if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
        checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR || ifid_pc !== 16'h0 || ifid_pc_next !== 16'h0) begin
            errors++;
            $display("FAIL reset_ifid got v=%b i=%h pc=%h pcn=%h exp v=0 i=0000 pc=0000 pcn=0000",
                     ifid_valid, ifid_instr, ifid_pc, ifid_pc_next);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
    endtask

    task automatic test_zero_wait;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0000", imem_req, imem_addr);
        end
        tick;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 16'h1234 || ifid_pc !== 16'h0000 || ifid_pc_next !== 16'h0002) begin
            errors++;
            $display("FAIL first_ifid got v=%b i=%h pc=%h pcn=%h exp v=1 i=1234 pc=0000 pcn=0002",
                     ifid_valid, ifid_instr, ifid_pc, ifid_pc_next);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
            errors++; $display("FAIL second_req got req=%b addr=%h exp req=1 addr=0002", imem_req, imem_addr);
        end
        tick;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 16'h0002 || ifid_instr !== 16'h1236 || imem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL b2b got v=%b pc=%h i=%h addr=%h exp v=1 pc=0002 i=1236 addr=0004",
                     ifid_valid, ifid_pc, ifid_instr, imem_addr);
        end
    endtask

    task automatic test_skid_stall;
        imem_ready = 1'b0;
        tick;
        stall_pc = 1'b1; stall_if_id = 1'b1; imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            errors++; $display("FAIL skid_wait_req got req=%b addr=%h exp req=1 addr=0004", imem_req, imem_addr);
        end
        tick;
        checks++;
        if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL skid_hold got req=%b v=%b exp req=0 v=0", imem_req, ifid_valid);
        end
        tick;
        stall_pc = 1'b0; stall_if_id = 1'b0;
        tick;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 16'h0004 || ifid_instr !== 16'h1238 || ifid_pc_next !== 16'h0006) begin
            errors++;
            $display("FAIL skid_drain got v=%b pc=%h i=%h pcn=%h exp v=1 pc=0004 i=1238 pcn=0006",
                     ifid_valid, ifid_pc, ifid_instr, ifid_pc_next);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
            errors++; $display("FAIL skid_next_req got req=%b addr=%h exp req=1 addr=0006", imem_req, imem_addr);
        end
        tick;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 16'h0006) begin
            errors++; $display("FAIL skid_no_dup got v=%b pc=%h exp v=1 pc=0006", ifid_valid, ifid_pc);
        end
    endtask

    task automatic test_wait_state;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall_pc = (i > 0);
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
                errors++; $display("FAIL wait_addr[%0d] got req=%b addr=%h exp req=1 addr=0008", i, imem_req, imem_addr);
            end
            tick;
            checks++;
            if (ifid_valid !== 1'b0) begin errors++; $display("FAIL wait_valid[%0d] got=%b exp=0", i, ifid_valid); end
        end
        stall_pc = 1'b0; imem_ready = 1'b1;
        tick;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 16'h0008 || ifid_instr !== 16'h123C) begin
            errors++; $display("FAIL wait_done got v=%b pc=%h i=%h exp v=1 pc=0008 i=123c", ifid_valid, ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_redirect_drop;
        imem_ready = 1'b0;
        tick;
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h000A) begin
            errors++; $display("FAIL redir_wait got req=%b addr=%h exp req=1 addr=000a", imem_req, imem_addr);
        end
        tick;
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h000A || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL drop_hold got req=%b addr=%h v=%b exp req=1 addr=000a v=0", imem_req, imem_addr, ifid_valid);
        end
        tick;
        imem_ready = 1'b1;
        tick;
        checks++;
        if (ifid_valid !== 1'b0 || imem_addr !== 16'h0040 || imem_req !== 1'b1) begin
            errors++; $display("FAIL drop_discard got v=%b addr=%h req=%b exp v=0 addr=0040 req=1", ifid_valid, imem_addr, imem_req);
        end
        tick;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 16'h0040 || ifid_instr !== 16'h1274) begin
            errors++; $display("FAIL redir_target got v=%b pc=%h i=%h exp v=1 pc=0040 i=1274", ifid_valid, ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_flush_stall;
        redirect_valid = 1'b1; redirect_pc = 16'h000A;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_no_req got=%b exp=0", imem_req); end
        tick;
        redirect_valid = 1'b0;
        tick;
        stall_if_id = 1'b1;
        tick;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 16'h000A) begin
            errors++; $display("FAIL fs_hold got v=%b pc=%h exp v=1 pc=000a", ifid_valid, ifid_pc);
        end
        flush_if_id = 1'b1;
        tick;
        checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== NOP_INSTR) begin
            errors++; $display("FAIL fs_bubble got v=%b i=%h exp v=0 i=0000", ifid_valid, ifid_instr);
        end
        flush_if_id = 1'b0; stall_if_id = 1'b0;
        tick;
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 16'h000C || ifid_instr !== 16'h1240 || imem_addr !== 16'h000E) begin
            errors++;
            $display("FAIL fs_skid_load got v=%b pc=%h i=%h addr=%h exp v=1 pc=000c i=1240 addr=000e",
                     ifid_valid, ifid_pc, ifid_instr, imem_addr);
        end
    endtask

    task automatic test_wrap_and_reset;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick;
        redirect_valid = 1'b0;
        tick;
        checks++;
        if (ifid_pc !== 16'hFFFE || ifid_pc_next !== 16'h0000 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL wrap got pc=%h pcn=%h addr=%h exp pc=fffe pcn=0000 addr=0000", ifid_pc, ifid_pc_next, imem_addr);
        end
        tick;
        imem_ready = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_wait got req=%b addr=%h v=%b exp req=0 addr=0000 v=0", imem_req, imem_addr, ifid_valid);
        end
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++; $display("FAIL rst_restart got req=%b addr=%h exp req=1 addr=0000", imem_req, imem_addr);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_skid_stall;
        test_wait_state;
        test_redirect_drop;
        test_flush_stall;
        test_wrap_and_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
